// File: rtl/game_ctrl_if.sv
// game_ctrl_if: control/status bundle between the game
// sequencer and the bar/score datapath.
interface game_ctrl_if;
  logic       start;
  logic       pause;
  logic [8:0] barpos;
  logic [3:0] holepos;
  logic [3:0] plrpos;
  logic       bar_step;
  logic       bar_reload;
  logic       score_tick;
  logic       score_clr;
  logic       hit;
  logic [1:0] lives;
  logic [1:0] state;

  modport master (
    output start, pause, barpos, holepos, plrpos,
    input  bar_step, bar_reload, score_tick,
    input  score_clr, hit, lives, state
  );

  modport slave (
    input  start, pause, barpos, holepos, plrpos,
    output bar_step, bar_reload, score_tick,
    output score_clr, hit, lives, state
  );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: falling-bar dodge game sequencer; derives bar and
// score enables from clb, detects collisions, tracks lives.
module game_ctrl #(
  parameter int BAR_DIV    = 4,
  parameter int SCORE_DIV  = 6,
  parameter int HIT_HOLD   = 8,
  parameter int LIVES_INIT = 3,
  parameter int PLR_ROW    = 400,
  parameter int BAR_END    = 479
) (
  input logic        clb,
  input logic        clr,
  game_ctrl_if.slave g
);

  localparam int BW = $clog2(BAR_DIV);
  localparam int SW = $clog2(SCORE_DIV);
  localparam int HW = $clog2(HIT_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } st_t;

  st_t         st;
  logic [BW-1:0] bdiv;
  logic [SW-1:0] sdiv;
  logic [HW-1:0] hold;
  logic [1:0]  lv;
  logic        step_q;
  logic        reload_q;
  logic        tick_q;
  logic        sclr_q;
  logic        hit_q;

  logic bev;
  logic sev;
  logic coll;
  logic recyc;

  assign bev   = (bdiv == BW'(BAR_DIV - 1));
  assign sev   = (sdiv == SW'(SCORE_DIV - 1));
  assign coll  = (g.barpos == 9'(PLR_ROW)) &&
                 (g.plrpos != g.holepos);
  assign recyc = (g.barpos >= 9'(BAR_END));

  always_ff @(posedge clb or negedge clr) begin
    if (!clr) begin
      st       <= IDLE;
      lv       <= 2'(LIVES_INIT);
      bdiv     <= '0;
      sdiv     <= '0;
      hold     <= '0;
      step_q   <= 1'b0;
      reload_q <= 1'b0;
      tick_q   <= 1'b0;
      sclr_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      step_q   <= 1'b0;
      reload_q <= 1'b0;
      tick_q   <= 1'b0;
      sclr_q   <= 1'b0;
      hit_q    <= 1'b0;
      unique case (st)
        IDLE, OVER: begin
          if (g.start) begin
            st       <= PLAY;
            lv       <= 2'(LIVES_INIT);
            sclr_q   <= 1'b1;
            reload_q <= 1'b1;
            bdiv     <= '0;
            sdiv     <= '0;
          end
        end
        PLAY: begin
          if (!g.pause) begin
            bdiv <= bev ? '0 : bdiv + 1'b1;
            sdiv <= sev ? '0 : sdiv + 1'b1;
            // a hit swallows any score tick due this cycle
            if (bev && coll) begin
              hit_q    <= 1'b1;
              reload_q <= 1'b1;
              if (lv <= 2'd1) begin
                lv <= 2'd0;
                st <= OVER;
              end else begin
                lv   <= lv - 2'd1;
                st   <= HIT;
                hold <= '0;
              end
            end else begin
              if (bev) begin
                if (recyc) reload_q <= 1'b1;
                else       step_q   <= 1'b1;
              end
              if (sev) tick_q <= 1'b1;
            end
          end
        end
        HIT: begin
          if (hold == HW'(HIT_HOLD - 1)) begin
            st   <= PLAY;
            hold <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign g.bar_step   = step_q;
  assign g.bar_reload = reload_q;
  assign g.score_tick = tick_q;
  assign g.score_clr  = sclr_q;
  assign g.hit        = hit_q;
  assign g.lives      = lv;
  assign g.state      = st;

endmodule
